sprite_painter: RTL and testbench
=================================

// Module: sprite_painter
// PURPOSE
//  Paints queued sprites into the hidden frame held in SRAM. It is the upstream producer of program_x/program_y/program_data for sram_controller.
//  Game logic pushes sprite commands (x, y, id) each frame. The painter fetches texels from a sprite ROM and presents one pixel at a time.
//  Transparent or off-screen texels are steered to a parked, never-displayed address, so the background survives underneath.
// PARAMETERS
//  SPRITE_W     32        sprite width in pixels (power of 2)
//  SPRITE_H     32        sprite height in pixels (power of 2)
//  ID_W         4         sprite id width; ROM holds 2**ID_W sprites
//  QUEUE_DEPTH  16        sprite command FIFO depth (power of 2)
//  PIXEL_HOLD   4         cycles each pixel is held on program_*; equals one controller round (two write slots)
//  TRANSPARENT  16'hF81F  colour key; matching texels are not drawn
// PORTS
//  sram_clk      in   1     100 MHz clock, same as sram_controller
//  reset         in   1     synchronous, active-high
//  frame_clk     in   1     frame toggle, same signal sram_controller sees
//  sprite_valid  in   1     push request
//  sprite_ready  out  1     FIFO not full
//  sprite_x      in   10    top-left X, 0..1023
//  sprite_y      in   10    top-left Y, 0..1023
//  sprite_id     in   ID_W  sprite index
//  rom_addr      out  ID_W+log2(W)+log2(H)  {id,row,col}; registered
//  rom_data      in   16    texel; valid 1 cycle after rom_addr
//  program_x     out  10    pixel X to controller
//  program_y     out  10    pixel Y to controller
//  program_data  out  16    pixel colour to controller
//  busy          out  1     painting or FIFO non-empty
//  frame_overrun out  1     sticky: a frame edge arrived while busy
// BEHAVIOUR
//  Reset values: program_x=1023, program_y=511 (park), program_data=0, rom_addr=0, sprite_ready=1, busy=0, frame_overrun=0.
//   Reset also empties the FIFO and enters IDLE. Reset mid-sprite aborts the sprite immediately.
//  Push: the command is accepted on an edge where sprite_valid && sprite_ready. A push while full is dropped; ready is already low.
//  Frame edge: detect the frame_clk rising edge with a registered delay (1 cycle of latency).
//   - On the detected edge, flush the FIFO and abort the current sprite. Go to IDLE and park outputs.
//   - If busy was 1 on that edge, set frame_overrun. It clears only on reset.
//   - A push on the same edge as the flush is kept, as the only FIFO entry.
//  FSM:
//   - IDLE: park. If the FIFO is non-empty, pop and go to LOAD.
//   - LOAD: latch cur_x/cur_y/cur_id; row=col=0; issue rom_addr; go to FETCH.
//   - FETCH: rom_data is valid. Register program_*; issue the next rom_addr; go to HOLD.
//   - HOLD: count PIXEL_HOLD-1 cycles, then advance col, wrapping col and incrementing row.
//     After (SPRITE_H-1, SPRITE_W-1), go to IDLE. Otherwise go back to FETCH.
//  Timing: a push at edge E into an empty, idle painter puts pixel (0,0) on program_* after edge E+3.
//   Each pixel is held exactly PIXEL_HOLD cycles. Between sprites, outputs are parked for exactly 2 cycles (IDLE, LOAD).
//  Pixel rule: px=cur_x+col and py=cur_y+row, computed 11 bits wide.
//   - If rom_data==TRANSPARENT, or px>=640, or py>=480: output park coordinates, program_data=0.
//   - Otherwise: program_x=px[9:0], program_y=py[9:0], program_data=rom_data.
//  Park address (1023,511) is outside the 640x480 window, so the controller's write there is harmless.
//  busy = (state!=IDLE) || FIFO non-empty.
// STRUCTURE
//  boxhead_pkg: SCREEN_W=640, SCREEN_H=480, PARK_X=1023, PARK_Y=511; typedef struct packed {x,y,id} sprite_cmd_t; painter state enum.
//  Sub-module sprite_cmd_fifo: synchronous FIFO of sprite_cmd_t, with push/pop/flush/full/empty. Flush has priority over pop, and push survives flush.
//  sprite_painter holds the edge detect, the FSM, the row/col/hold counters and the output registers.
// TESTING
//  1. Reset, then push (x=100,y=50,id=2), with the ROM returning all 16'h07E0.
//     -> pixel (100,50) appears after edge E+3. Then (101,50) 4 cycles later, and so on up to (131,81). 1024 pixels, then IDLE with park.
//  2. ROM returns TRANSPARENT for even columns.
//     -> even-column cycles show (1023,511, data 0); odd columns show real coordinates.
//  3. Push x=620,y=470.
//     -> only the 20x10 on-screen pixels are non-park; px>=640 and py>=480 park; no wrap to low coordinates.
//  4. Push 17 commands back-to-back with no drain.
//     -> sprite_ready falls after 16 (or 17 if one popped); the extra command is dropped; FIFO order is preserved.
//  5. Frame edge mid-sprite, with a push on the same edge.
//     -> frame_overrun=1, outputs park, and the new command paints next. Another edge while idle leaves the flag sticky and no new set.
//  6. Assert reset during HOLD.
//     -> next cycle all outputs equal the reset values, busy=0, and the FIFO is empty.

Source files
------------

// File: rtl/sprite_painter_pkg.sv
// Shared types and screen constants for the sprite painter and its command FIFO.
package sprite_painter_pkg;

    localparam int         SCREEN_W = 640;
    localparam int         SCREEN_H = 480;
    localparam logic [9:0] PARK_X   = 10'd1023;
    localparam logic [9:0] PARK_Y   = 10'd511;
    localparam int         CMD_ID_W = 4;

    typedef struct packed {
        logic [9:0]          x;
        logic [9:0]          y;
        logic [CMD_ID_W-1:0] id;
    } sprite_cmd_t;

    typedef enum logic [1:0] {IDLE, LOAD, FETCH, HOLD} paint_state_t;

endpackage

// File: rtl/sprite_painter_if.sv
// Sprite command push channel from game logic into the painter.
interface sprite_painter_if #(parameter int ID_W = 4);
    logic            sprite_valid;
    logic            sprite_ready;
    logic [9:0]      sprite_x;
    logic [9:0]      sprite_y;
    logic [ID_W-1:0] sprite_id;

    modport master (output sprite_valid, sprite_x, sprite_y, sprite_id, input sprite_ready);
    modport slave  (input sprite_valid, sprite_x, sprite_y, sprite_id, output sprite_ready);
endinterface

// File: rtl/sprite_painter_cmd_fifo.sv
// Synchronous sprite command FIFO; flush beats pop, and a push on the flush edge becomes the sole entry.
module sprite_cmd_fifo
    import sprite_painter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  sprite_cmd_t din,
    output sprite_cmd_t dout,
    output logic        full,
    output logic        empty
);
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = DEPTH[AW:0];

    sprite_cmd_t     mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     count;
    logic            do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= {{(AW-1){1'b0}}, do_push};
            count  <= {{AW{1'b0}}, do_push};
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= din;
    end

endmodule

// File: rtl/sprite_painter.sv
// Walks queued sprites texel by texel and presents one pixel per PIXEL_HOLD cycles to the SRAM controller.
module sprite_painter
    import sprite_painter_pkg::*;
#(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          ID_W        = CMD_ID_W,
    parameter int          QUEUE_DEPTH = 16,
    parameter int          PIXEL_HOLD  = 4,
    parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
    input  logic                                             sram_clk,
    input  logic                                             reset,
    input  logic                                             frame_clk,
    sprite_painter_if.slave                                  spr,
    output logic [ID_W+$clog2(SPRITE_W)+$clog2(SPRITE_H)-1:0] rom_addr,
    input  logic [15:0]                                      rom_data,
    output logic [9:0]                                       program_x,
    output logic [9:0]                                       program_y,
    output logic [15:0]                                      program_data,
    output logic                                             busy,
    output logic                                             frame_overrun
);
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int HOLD_W = $clog2(PIXEL_HOLD);

    paint_state_t      state, state_n;
    sprite_cmd_t       cur, head, push_cmd;
    logic [COL_W-1:0]  col, nxt_col;
    logic [ROW_W-1:0]  row, nxt_row;
    logic [HOLD_W-1:0] hold_cnt;
    logic              frame_prev, frame_edge;
    logic              push, pop, full, empty;
    logic              last_col, last_pix, hold_done, visible;
    logic [10:0]       px, py;

    assign frame_edge       = frame_clk && !frame_prev;
    assign spr.sprite_ready = !full;
    assign push             = spr.sprite_valid && !full;
    assign pop              = (state == IDLE) && !empty;
    assign busy             = (state != IDLE) || !empty;
    assign push_cmd         = '{x: spr.sprite_x, y: spr.sprite_y, id: spr.sprite_id};

    sprite_cmd_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk   (sram_clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (frame_edge),
        .din   (push_cmd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign last_col  = (col == COL_W'(SPRITE_W - 1));
    assign last_pix  = last_col && (row == ROW_W'(SPRITE_H - 1));
    assign nxt_col   = col + 1'b1;
    assign nxt_row   = last_col ? row + 1'b1 : row;
    assign hold_done = (hold_cnt == HOLD_W'(PIXEL_HOLD - 1));

    // 11-bit sums so a sprite hanging off the right/bottom edge never wraps to low coordinates
    assign px      = {1'b0, cur.x} + 11'(col);
    assign py      = {1'b0, cur.y} + 11'(row);
    assign visible = (rom_data != TRANSPARENT) && (px < 11'(SCREEN_W)) && (py < 11'(SCREEN_H));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!empty) state_n = LOAD;
            LOAD:    state_n = FETCH;
            FETCH:   state_n = HOLD;
            HOLD:    if (hold_done) state_n = last_pix ? IDLE : FETCH;
            default: state_n = IDLE;
        endcase
        if (frame_edge) state_n = IDLE;
    end

    always_ff @(posedge sram_clk) begin
        if (reset) begin
            state         <= IDLE;
            cur           <= '0;
            row           <= '0;
            col           <= '0;
            hold_cnt      <= '0;
            rom_addr      <= '0;
            program_x     <= PARK_X;
            program_y     <= PARK_Y;
            program_data  <= '0;
            frame_overrun <= 1'b0;
            frame_prev    <= frame_clk;
        end else begin
            state      <= state_n;
            frame_prev <= frame_clk;
            if (frame_edge && busy) frame_overrun <= 1'b1;
            if (frame_edge) begin
                program_x    <= PARK_X;
                program_y    <= PARK_Y;
                program_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        program_x    <= PARK_X;
                        program_y    <= PARK_Y;
                        program_data <= '0;
                        if (!empty) cur <= head;
                    end
                    LOAD: begin
                        row      <= '0;
                        col      <= '0;
                        rom_addr <= {cur.id, {ROW_W{1'b0}}, {COL_W{1'b0}}};
                    end
                    FETCH: begin
                        program_x    <= visible ? px[9:0] : PARK_X;
                        program_y    <= visible ? py[9:0] : PARK_Y;
                        program_data <= visible ? rom_data : 16'h0000;
                        // prefetch the next texel so it is settled by the next FETCH
                        rom_addr     <= {cur.id, nxt_row, nxt_col};
                        hold_cnt     <= HOLD_W'(1);
                    end
                    HOLD: begin
                        if (hold_done) begin
                            col <= nxt_col;
                            row <= nxt_row;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_painter.sv
// Scoreboard bench for sprite_painter: expected pixels are queued at push time and popped as pixels appear.
module tb_sprite_painter;
    localparam int ID_W = 4;
    localparam int RA_W = ID_W + 10;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } pix_t;

    logic            sram_clk = 1'b0;
    logic            reset    = 1'b1;
    logic            frame_clk = 1'b0;
    logic [RA_W-1:0] rom_addr;
    logic [15:0]     rom_data;
    logic [9:0]      program_x, program_y;
    logic [15:0]     program_data;
    logic            busy, frame_overrun;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   rom_mode = 0;
    pix_t exp_q[$];

    sprite_painter_if #(.ID_W(ID_W)) sif();

    sprite_painter dut (
        .sram_clk      (sram_clk),
        .reset         (reset),
        .frame_clk     (frame_clk),
        .spr           (sif),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .program_x     (program_x),
        .program_y     (program_y),
        .program_data  (program_data),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    always #5 sram_clk = ~sram_clk;

    function automatic logic [15:0] rom_fn(input logic [RA_W-1:0] a, input int mode);
        if (mode == 0)
            return 16'h07E0;
        else if (mode == 1 && a[0] == 1'b0)
            return 16'hF81F;
        else
            return 16'h4000 | {2'b00, a};
    endfunction

    always_comb rom_data = rom_fn(rom_addr, rom_mode);

    function automatic pix_t model_pix(input int x, input int y, input int id, input int row, input int col);
        pix_t            p;
        logic [RA_W-1:0] a;
        logic [15:0]     d;
        int              px, py;
        a  = {4'(id), 5'(row), 5'(col)};
        d  = rom_fn(a, rom_mode);
        px = x + col;
        py = y + row;
        if (d == 16'hF81F || px >= 640 || py >= 480) begin
            p.x = 10'd1023; p.y = 10'd511; p.d = 16'h0000;
        end else begin
            p.x = 10'(px); p.y = 10'(py); p.d = d;
        end
        return p;
    endfunction

    task automatic push_cmd(input int x, input int y, input int id);
        @(negedge sram_clk);
        sif.sprite_valid = 1'b1;
        sif.sprite_x     = 10'(x);
        sif.sprite_y     = 10'(y);
        sif.sprite_id    = 4'(id);
        @(negedge sram_clk);
        sif.sprite_valid = 1'b0;
    endtask

    task automatic check_park(input string name);
        n_checks++;
        if ({program_x, program_y, program_data} !== {10'd1023, 10'd511, 16'h0000}) begin
            n_fail++;
            $display("FAIL %s: got (%0d,%0d,%h) expected (1023,511,0000)", name, program_x, program_y, program_data);
        end
    endtask

    // Push one sprite into an idle painter and check all of its pixels plus the park afterwards.
    task automatic paint_and_check(input int x, input int y, input int id, input string name, output int on_cnt);
        pix_t got, exp;
        on_cnt = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                exp_q.push_back(model_pix(x, y, id, r, c));
        push_cmd(x, y, id);
        repeat (3) @(negedge sram_clk);
        for (int i = 0; i < 1024; i++) begin
            got = {program_x, program_y, program_data};
            exp = exp_q.pop_front();
            if (got.x != 10'd1023) on_cnt++;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s pixel %0d: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                         name, i, got.x, got.y, got.d, exp.x, exp.y, exp.d);
            end
            if (i != 1023) repeat (4) @(negedge sram_clk);
        end
        repeat (4) @(negedge sram_clk);
        check_park({name, "_end_park"});
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end_busy: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sram_clk);
        check_park("reset_park");
        n_checks++;
        if ({rom_addr, sif.sprite_ready, busy, frame_overrun} !== {{RA_W{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_ctrl: got addr=%h ready=%b busy=%b ovr=%b expected 0,1,0,0",
                     rom_addr, sif.sprite_ready, busy, frame_overrun);
        end
        reset = 1'b0;
        @(negedge sram_clk);
        frame_clk = 1'b1;
        repeat (2) @(negedge sram_clk);
        n_checks++;
        if (frame_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_frame_no_overrun: got %b expected 0", frame_overrun);
        end
        frame_clk = 1'b0;
        @(negedge sram_clk);
    endtask

    task automatic test_solid();
        int on_cnt;
        rom_mode = 0;
        paint_and_check(100, 50, 2, "solid", on_cnt);
    endtask

    task automatic test_transparent();
        int on_cnt;
        rom_mode = 1;
        paint_and_check(300, 200, 5, "transparent", on_cnt);
        n_checks++;
        if (on_cnt != 512) begin
            n_fail++;
            $display("FAIL transparent_count: got %0d expected 512", on_cnt);
        end
    endtask

    task automatic test_clip();
        int on_cnt;
        rom_mode = 2;
        paint_and_check(620, 470, 7, "clip", on_cnt);
        n_checks++;
        if (on_cnt != 200) begin
            n_fail++;
            $display("FAIL clip_count: got %0d expected 200", on_cnt);
        end
    endtask

    task automatic test_frame();
        pix_t exp;
        rom_mode = 0;
        push_cmd(0, 0, 1);
        repeat (50) @(negedge sram_clk);
        frame_clk        = 1'b1;
        sif.sprite_valid = 1'b1;
        sif.sprite_x     = 10'd200;
        sif.sprite_y     = 10'd100;
        sif.sprite_id    = 4'd3;
        exp_q.push_back(model_pix(200, 100, 3, 0, 0));
        @(negedge sram_clk);
        sif.sprite_valid = 1'b0;
        check_park("frame_flush_park");
        n_checks++;
        if ({frame_overrun, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL frame_overrun_set: got ovr=%b busy=%b expected 1,1", frame_overrun, busy);
        end
        repeat (3) @(negedge sram_clk);
        exp = exp_q.pop_front();
        n_checks++;
        if ({program_x, program_y, program_data} !== exp) begin
            n_fail++;
            $display("FAIL frame_kept_push: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                     program_x, program_y, program_data, exp.x, exp.y, exp.d);
        end
        repeat (10) @(negedge sram_clk);
        frame_clk = 1'b0;
        repeat (10) @(negedge sram_clk);
        frame_clk = 1'b1;
        @(negedge sram_clk);
        check_park("frame_abort_park");
        n_checks++;
        if ({frame_overrun, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL frame_abort_flush: got ovr=%b busy=%b expected 1,0", frame_overrun, busy);
        end
        repeat (5) @(negedge sram_clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge sram_clk);
        frame_clk = 1'b1;
        @(negedge sram_clk);
        n_checks++;
        if ({frame_overrun, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL frame_idle_sticky: got ovr=%b busy=%b expected 1,0", frame_overrun, busy);
        end
        frame_clk = 1'b0;
        @(negedge sram_clk);
    endtask

    // 17 pushes on consecutive edges; the first is popped at once so the FIFO ends exactly full.
    task automatic test_back_to_back();
        pix_t exp;
        rom_mode = 2;
        @(negedge sram_clk);
        for (int k = 0; k < 17; k++) begin
            if (k == 4) begin
                exp = exp_q.pop_front();
                n_checks++;
                if ({program_x, program_y, program_data} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_sprite0: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                             program_x, program_y, program_data, exp.x, exp.y, exp.d);
                end
            end
            sif.sprite_valid = 1'b1;
            sif.sprite_x     = 10'(10 * k);
            sif.sprite_y     = 10'(k);
            sif.sprite_id    = 4'(k);
            exp_q.push_back(model_pix(10 * k, k, k % 16, 0, 0));
            @(negedge sram_clk);
        end
        n_checks++;
        if (sif.sprite_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got ready=%b expected 0", sif.sprite_ready);
        end
        sif.sprite_x  = 10'd170;
        sif.sprite_y  = 10'd17;
        sif.sprite_id = 4'd1;
        @(negedge sram_clk);
        sif.sprite_valid = 1'b0;
        n_checks++;
        if ({sif.sprite_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_drop: got ready=%b busy=%b expected 0,1", sif.sprite_ready, busy);
        end
        repeat (4 + 4098 - 18) @(negedge sram_clk);
        for (int s = 1; s <= 2; s++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if ({program_x, program_y, program_data} !== exp) begin
                n_fail++;
                $display("FAIL b2b_sprite%0d: got (%0d,%0d,%h) expected (%0d,%0d,%h)",
                         s, program_x, program_y, program_data, exp.x, exp.y, exp.d);
            end
            if (s == 1) repeat (4098) @(negedge sram_clk);
        end
    endtask

    task automatic test_reset_mid_sprite();
        reset = 1'b1;
        @(negedge sram_clk);
        check_park("midreset_park");
        n_checks++;
        if ({rom_addr, sif.sprite_ready, busy, frame_overrun} !== {{RA_W{1'b0}}, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got addr=%h ready=%b busy=%b ovr=%b expected 0,1,0,0",
                     rom_addr, sif.sprite_ready, busy, frame_overrun);
        end
        reset = 1'b0;
        exp_q.delete();
        repeat (6) @(negedge sram_clk);
        check_park("midreset_stays_parked");
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_fifo_empty: got busy=%b expected 0", busy);
        end
    endtask

    initial begin
        sif.sprite_valid = 1'b0;
        sif.sprite_x     = '0;
        sif.sprite_y     = '0;
        sif.sprite_id    = '0;
        test_reset();
        test_solid();
        test_transparent();
        test_clip();
        test_frame();
        test_back_to_back();
        test_reset_mid_sprite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
